// File: rtl/la_idiffrx_pkg.sv
// Shared definitions for the differential input receiver: per-channel state
// encoding and counter width helpers.
package la_idiffrx_pkg;

  typedef enum logic [1:0] {
    ST_STABLE = 2'd0,
    ST_CAND   = 2'd1,
    ST_NDIFF  = 2'd2
  } rx_state_e;

  // Counters hold 0..limit inclusive and saturate at limit.
  function automatic int filt_cnt_w(input int filter);
    return $clog2(filter + 1);
  endfunction

  function automatic int fault_cnt_w(input int faultlen);
    return $clog2(faultlen + 1);
  endfunction

endpackage

// File: rtl/la_idiffrx_ch.sv
// One receiver channel: pad synchroniser, pair decode, deglitch filter and
// sticky non-differential fault detection.
module la_idiffrx_ch
  import la_idiffrx_pkg::*;
#(
  parameter int DIFF     = 1,
  parameter int SYNC     = 2,
  parameter int FILTER   = 4,
  parameter int FAULTLEN = 8,
  parameter     PROP     = "DEFAULT"
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  input  logic inb,
  input  logic clear,
  output logic z,
  output logic valid,
  output logic fault
);

  localparam int FW = filt_cnt_w(FILTER);
  localparam int CW = fault_cnt_w(FAULTLEN);
  localparam logic [FW-1:0] FMAX  = FW'(FILTER);
  localparam logic [CW-1:0] FLMAX = CW'(FAULTLEN);

  // Pads land directly on the first flop. inb resets high so the idle pair
  // decodes as a valid 0.
  logic [SYNC-1:0] in_sync, inb_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_sync  <= '0;
      inb_sync <= '1;
    end else begin
      in_sync  <= {in_sync[SYNC-2:0], in};
      inb_sync <= {inb_sync[SYNC-2:0], inb};
    end
  end

  logic in_s, inb_s, ok, d;
  assign in_s  = in_sync[SYNC-1];
  assign inb_s = inb_sync[SYNC-1];
  assign ok    = (DIFF > 0) ? (in_s ^ inb_s) : 1'b1;
  assign d     = in_s;

  rx_state_e       state, state_n;
  logic [FW-1:0]   fcnt, fcnt_n, cnt_inc;
  logic [CW-1:0]   flt, flt_n;
  logic            z_n, fault_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_STABLE;
      fcnt  <= '0;
      flt   <= '0;
      z     <= 1'b0;
      valid <= 1'b1;
      fault <= 1'b0;
    end else begin
      state <= state_n;
      fcnt  <= fcnt_n;
      flt   <= flt_n;
      z     <= z_n;
      valid <= ok;
      fault <= fault_n;
    end
  end

  always_comb begin
    state_n = state;
    fcnt_n  = fcnt;
    flt_n   = flt;
    z_n     = z;
    cnt_inc = FW'(1);
    if (!ok) begin
      // Non-differential sample: hold z, abort any candidate.
      state_n = ST_NDIFF;
      fcnt_n  = '0;
      flt_n   = (flt == FLMAX) ? flt : flt + 1'b1;
    end else begin
      flt_n = '0;
      if (d == z) begin
        state_n = ST_STABLE;
        fcnt_n  = '0;
      end else begin
        // A fresh candidate (from STABLE or NDIFF) starts at one sample.
        if (state == ST_CAND)
          cnt_inc = (fcnt == FMAX) ? fcnt : fcnt + 1'b1;
        if (cnt_inc == FMAX) begin
          z_n     = d;
          state_n = ST_STABLE;
          fcnt_n  = '0;
        end else begin
          state_n = ST_CAND;
          fcnt_n  = cnt_inc;
        end
      end
    end
    // A persisting fault beats a concurrent clear.
    if (!ok && flt_n == FLMAX)
      fault_n = 1'b1;
    else if (clear)
      fault_n = 1'b0;
    else
      fault_n = fault;
  end

endmodule

// File: rtl/la_idiffrx.sv
// Multi-channel differential pad receiver: N independent channels, each
// synchronised, deglitched and monitored for non-differential inputs.
module la_idiffrx
  import la_idiffrx_pkg::*;
#(
  parameter int N        = 1,
  parameter int DIFF     = 1,
  parameter int SYNC     = 2,
  parameter int FILTER   = 4,
  parameter int FAULTLEN = 8,
  parameter     PROP     = "DEFAULT"
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] in,
  input  logic [N-1:0] inb,
  input  logic [N-1:0] clear,
  output logic [N-1:0] z,
  output logic [N-1:0] valid,
  output logic [N-1:0] fault
);

  for (genvar i = 0; i < N; i++) begin : g_ch
    la_idiffrx_ch #(
      .DIFF     (DIFF),
      .SYNC     (SYNC),
      .FILTER   (FILTER),
      .FAULTLEN (FAULTLEN),
      .PROP     (PROP)
    ) u_ch (
      .clk   (clk),
      .reset (reset),
      .in    (in[i]),
      .inb   (inb[i]),
      .clear (clear[i]),
      .z     (z[i]),
      .valid (valid[i]),
      .fault (fault[i])
    );
  end

endmodule

// File: tb/tb_la_idiffrx.sv
// Scoreboard bench: stimulus queues expected outputs tagged with a target
// cycle; a negedge monitor compares and retires them.
module tb_la_idiffrx;

  localparam int DA = 0, DB = 1, DC = 2;
  localparam int SZ = 0, SV = 1, SF = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0] a_in, a_inb, a_clr, a_z, a_v, a_f;
  logic [3:0] b_in, b_inb, b_clr, b_z, b_v, b_f;
  logic       c_in, c_inb, c_clr, c_z, c_v, c_f;

  la_idiffrx #(.N(2), .DIFF(1), .SYNC(2), .FILTER(4), .FAULTLEN(8), .PROP("DEFAULT")) u_a (
    .clk(clk), .reset(reset), .in(a_in), .inb(a_inb), .clear(a_clr),
    .z(a_z), .valid(a_v), .fault(a_f));

  la_idiffrx #(.N(4), .DIFF(1), .SYNC(2), .FILTER(4), .FAULTLEN(8), .PROP("DEFAULT")) u_b (
    .clk(clk), .reset(reset), .in(b_in), .inb(b_inb), .clear(b_clr),
    .z(b_z), .valid(b_v), .fault(b_f));

  la_idiffrx #(.N(1), .DIFF(0), .SYNC(2), .FILTER(4), .FAULTLEN(8), .PROP("DEFAULT")) u_c (
    .clk(clk), .reset(reset), .in(c_in), .inb(c_inb), .clear(c_clr),
    .z(c_z), .valid(c_v), .fault(c_f));

  typedef struct {
    int         at;
    string      nm;
    int         dut;
    int         sig;
    logic [3:0] v;
  } exp_t;

  exp_t q[$];
  int   nchk  = 0;
  int   npass = 0;

  function automatic logic [3:0] get(input int dut, input int sig);
    logic [3:0] r;
    r = '0;
    case (dut)
      DA: case (sig) SZ: r = {2'b00, a_z}; SV: r = {2'b00, a_v}; default: r = {2'b00, a_f}; endcase
      DB: case (sig) SZ: r = b_z; SV: r = b_v; default: r = b_f; endcase
      default: case (sig) SZ: r = {3'b000, c_z}; SV: r = {3'b000, c_v}; default: r = {3'b000, c_f}; endcase
    endcase
    return r;
  endfunction

  function automatic void ex(input int dt, input string nm, input int dut, input int sig,
                             input logic [3:0] v);
    exp_t e;
    e.at = cyc + dt; e.nm = nm; e.dut = dut; e.sig = sig; e.v = v;
    q.push_back(e);
  endfunction

  function automatic void ex3(input int dt, input string nm, input int dut,
                              input logic [3:0] vz, input logic [3:0] vv, input logic [3:0] vf);
    ex(dt, {nm, "_z"}, dut, SZ, vz);
    ex(dt, {nm, "_v"}, dut, SV, vv);
    ex(dt, {nm, "_f"}, dut, SF, vf);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: retire every expectation whose target cycle has arrived.
  initial begin : mon
    logic [3:0] act;
    forever begin
      @(negedge clk);
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].at <= cyc) begin
          act  = get(q[i].dut, q[i].sig);
          nchk = nchk + 1;
          if (act === q[i].v && q[i].at == cyc)
            npass = npass + 1;
          else
            $display("FAIL %s @cyc %0d: got %h want %h", q[i].nm, cyc, act, q[i].v);
          q.delete(i);
        end
      end
    end
  end

  initial begin
    a_in = '0; a_inb = '1; a_clr = '0;
    b_in = '0; b_inb = '1; b_clr = '0;
    c_in = 1'b0; c_inb = 1'b1; c_clr = 1'b0;

    tick(2);
    ex3(0, "rst_a", DA, 4'h0, 4'h3, 4'h0);
    ex3(0, "rst_b", DB, 4'h0, 4'hf, 4'h0);
    ex3(0, "rst_c", DC, 4'h0, 4'h1, 4'h0);
    reset = 1'b0;
    tick(3);

    // Latency: ch1 steps to 1/0, z rises SYNC+FILTER edges later.
    a_in[1] = 1'b1; a_inb[1] = 1'b0;
    ex(3, "lat_v3", DA, SV, 4'h3);
    ex(5, "lat_z5", DA, SZ, 4'h0);
    ex(6, "lat_z6", DA, SZ, 4'h2);
    ex(6, "lat_v6", DA, SV, 4'h3);
    tick(8);

    // ch1 goes non-differential and stays there; fault after 8 samples.
    a_inb[1] = 1'b1;
    ex(3,  "nd_v3",  DA, SV, 4'h1);
    ex(9,  "nd_f9",  DA, SF, 4'h0);
    ex(10, "nd_f10", DA, SF, 4'h2);
    ex(10, "nd_z10", DA, SZ, 4'h2);
    ex(10, "nd_v10", DA, SV, 4'h1);
    tick(6);
    a_in[0] = 1'b1; a_inb[0] = 1'b0;
    tick(5);
    // ch0 is mid-candidate, ch1 has z=1 and fault=1: async reset.
    reset = 1'b1;
    ex3(0, "rst_async", DA, 4'h0, 4'h3, 4'h0);
    tick(2);
    ex3(0, "rst_held", DA, 4'h0, 4'h3, 4'h0);
    reset = 1'b0;
    ex3(2, "rel2", DA, 4'h0, 4'h3, 4'h0);
    ex(3,  "rel_v3",  DA, SV, 4'h1);
    ex(5,  "rel_z5",  DA, SZ, 4'h0);
    ex(6,  "rel_z6",  DA, SZ, 4'h1);
    ex(9,  "rel_f9",  DA, SF, 4'h0);
    ex(10, "rel_f10", DA, SF, 4'h2);
    tick(11);

    // ch1 recovers; fault must stay sticky, then clear drops it.
    a_inb[1] = 1'b0;
    ex(3, "rec_v",  DA, SV, 4'h3);
    ex(6, "rec_z",  DA, SZ, 4'h3);
    ex(8, "sticky", DA, SF, 4'h2);
    tick(8);
    a_clr[1] = 1'b1;
    ex(0, "pre_clr", DA, SF, 4'h2);
    ex(1, "clr",     DA, SF, 4'h0);
    tick(1);
    a_clr = '0;
    tick(3);

    // ch0 back to 0, then glitch tests.
    a_in[0] = 1'b0; a_inb[0] = 1'b1;
    ex(6, "fall", DA, SZ, 4'h2);
    tick(8);
    a_in[0] = 1'b1; a_inb[0] = 1'b0;
    ex(6, "gl3_z6", DA, SZ, 4'h2);
    ex(9, "gl3_z9", DA, SZ, 4'h2);
    tick(3);
    a_in[0] = 1'b0; a_inb[0] = 1'b1;
    tick(8);
    a_in[0] = 1'b1; a_inb[0] = 1'b0;
    ex(5, "gl4_z5", DA, SZ, 4'h2);
    ex(6, "gl4_z6", DA, SZ, 4'h3);
    tick(4);
    a_in[0] = 1'b0; a_inb[0] = 1'b1;
    tick(10);

    // Short non-diff on ch1 (7 samples): no fault, z holds 1.
    a_inb[1] = 1'b1;
    ex(3,  "nds_v3",  DA, SV, 4'h1);
    ex(9,  "nds_v9",  DA, SV, 4'h1);
    ex(9,  "nds_z9",  DA, SZ, 4'h2);
    ex(10, "nds_v10", DA, SV, 4'h3);
    ex(12, "nds_f12", DA, SF, 4'h0);
    ex(12, "nds_z12", DA, SZ, 4'h2);
    tick(7);
    a_inb[1] = 1'b0;
    tick(8);

    // Clear held during persistent in=inb=0: set wins until the pair recovers.
    a_in[1] = 1'b0; a_inb[1] = 1'b0;
    ex(10, "cvf_f10", DA, SF, 4'h2);
    tick(10);
    a_clr[1] = 1'b1;
    ex(2, "cvf_f12", DA, SF, 4'h2);
    ex(4, "cvf_f14", DA, SF, 4'h2);
    tick(4);
    a_inb[1] = 1'b1;
    ex(2, "cvf_f16", DA, SF, 4'h2);
    ex(3, "cvf_clr", DA, SF, 4'h0);
    ex(6, "cvf_z",   DA, SZ, 4'h0);
    tick(3);
    a_clr = '0;
    tick(6);

    // Four channels, fault only on ch2.
    b_in = 4'b1101; b_inb = 4'b0110;
    ex(3,  "b_v",  DB, SV, 4'b1011);
    ex(6,  "b_z",  DB, SZ, 4'b1001);
    ex(9,  "b_f9", DB, SF, 4'b0000);
    ex(10, "b_f",  DB, SF, 4'b0100);
    tick(12);
    b_in = 4'b0111; b_inb = 4'b1100;
    ex(5, "b_z5", DB, SZ, 4'b1001);
    ex(6, "b_z6", DB, SZ, 4'b0011);
    ex(6, "b_f6", DB, SF, 4'b0100);
    tick(8);

    // Single-ended mode: inb is ignored.
    c_in = 1'b1;
    ex(5, "c_z5", DC, SZ, 4'h0);
    ex(6, "c_z6", DC, SZ, 4'h1);
    for (int i = 0; i < 12; i++) begin
      c_inb = 1'($urandom_range(0, 1));
      ex(0, "c_v", DC, SV, 4'h1);
      ex(0, "c_f", DC, SF, 4'h0);
      tick(1);
    end
    tick(4);

    for (int k = 0; k < 50 && q.size() > 0; k++) tick(1);
    if (q.size() > 0) begin
      $display("FAIL drain: %0d expectations never reached", q.size());
      nchk = nchk + q.size();
    end
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
